// File: rtl/soc_dmem_ctrl.sv
// Multi-port data memory: round-robin arbiter, one access per cycle, fixed-latency tagged responses.
// Define SOC_DMEM_RANGE_CHK_EN to flag out-of-range addresses on resp_err instead of aliasing them.
module soc_dmem_ctrl #(
  parameter int MEM_DEPTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS = 2,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  resp_rdata
`ifdef SOC_DMEM_RANGE_CHK_EN
  ,
  output logic [NUM_PORTS-1:0]             resp_err
`endif
);

  localparam int AW = ADDR_WIDTH;
  localparam int AW1 = AW + 1;
  localparam int DW = DATA_WIDTH;
  localparam int L = READ_LATENCY;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);
  localparam logic [AW:0] DEPTH = AW1'(MEM_DEPTH);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;
  logic          found;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [AW-1:0] mem_idx;
  logic [DW-1:0] acc_wdata;
  logic [DW-1:0] rd_data;
  logic          oob;
  logic          wr_en;

  logic [DW-1:0] mem_q [MEM_DEPTH];

  logic [L-1:0]         vld_q;
  logic [L-1:0][PW-1:0] pid_q;
  logic [L-1:0][DW-1:0] dat_q;

  always_comb begin
    int idx;
    idx = 0;
    found = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_PORTS;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    found = found & ~reset;
    req_ready = '0;
    if (found) req_ready[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    acc_we = req_we[gnt_idx];
    acc_addr = req_addr[gnt_idx*AW +: AW];
    acc_wdata = req_wdata[gnt_idx*DW +: DW];
`ifdef SOC_DMEM_RANGE_CHK_EN
    oob = ({1'b0, acc_addr} >= DEPTH);
    mem_idx = oob ? '0 : acc_addr;
`else
    // Non-power-of-two depth: fold the unused top range back onto the lower half
    oob = 1'b0;
    mem_idx = ({1'b0, acc_addr} >= DEPTH)
            ? acc_addr - (AW'(1) << (AW - 1))
            : acc_addr;
`endif
    wr_en = found & acc_we & ~oob;
    rd_data = (acc_we || oob) ? '0 : mem_q[mem_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[mem_idx] <= acc_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      vld_q <= '0;
      pid_q <= '0;
      dat_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = L - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        pid_q[i] <= pid_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      vld_q[0] <= found;
      pid_q[0] <= gnt_idx;
      dat_q[0] <= rd_data;
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (vld_q[L-1]) begin
      resp_valid[pid_q[L-1]] = 1'b1;
      resp_rdata[pid_q[L-1]*DW +: DW] = dat_q[L-1];
    end
  end

`ifdef SOC_DMEM_RANGE_CHK_EN
  logic [L-1:0] err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      for (int i = L - 1; i > 0; i--) err_q[i] <= err_q[i-1];
      err_q[0] <= found & oob;
    end
  end

  always_comb begin
    resp_err = '0;
    if (vld_q[L-1]) resp_err[pid_q[L-1]] = err_q[L-1];
  end
`endif

endmodule

// File: tb/tb_soc_dmem_ctrl.sv
// Directed bench for soc_dmem_ctrl: a default 2-port/latency-1 instance
// and a 3-port/latency-3/depth-48 instance.
module tb_soc_dmem_ctrl;

  logic clk = 1'b1;
  logic reset = 1'b1;

  logic [1:0]  a_valid, a_we, a_ready, a_rv;
  logic [11:0] a_addr;
  logic [63:0] a_wdata, a_rdata;

  logic [2:0]  b_valid, b_we, b_ready, b_rv;
  logic [17:0] b_addr;
  logic [95:0] b_wdata, b_rdata;
`ifdef SOC_DMEM_RANGE_CHK_EN
  logic [1:0]  a_err;
  logic [2:0]  b_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  soc_dmem_ctrl u_a (
    .clk(clk),
    .reset(reset),
    .req_valid(a_valid),
    .req_ready(a_ready),
    .req_we(a_we),
    .req_addr(a_addr),
    .req_wdata(a_wdata),
    .resp_valid(a_rv),
    .resp_rdata(a_rdata)
`ifdef SOC_DMEM_RANGE_CHK_EN
    ,
    .resp_err(a_err)
`endif
  );

  soc_dmem_ctrl #(
    .MEM_DEPTH(48),
    .DATA_WIDTH(32),
    .NUM_PORTS(3),
    .READ_LATENCY(3)
  ) u_b (
    .clk(clk),
    .reset(reset),
    .req_valid(b_valid),
    .req_ready(b_ready),
    .req_we(b_we),
    .req_addr(b_addr),
    .req_wdata(b_wdata),
    .resp_valid(b_rv),
    .resp_rdata(b_rdata)
`ifdef SOC_DMEM_RANGE_CHK_EN
    ,
    .resp_err(b_err)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic b_req(input int p, input logic we,
                       input logic [5:0] addr, input logic [31:0] d);
    b_valid[p] = 1'b1;
    b_we[p] = we;
    b_addr[p*6 +: 6] = addr;
    b_wdata[p*32 +: 32] = d;
  endtask

  initial begin
    logic [2:0]  ev;
    logic [95:0] ed;
    logic [2:0]  er;
    a_valid = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_valid = '0; b_we = '0; b_addr = '0; b_wdata = '0;

    // reset: requests present but nothing granted
    a_valid = 2'b01; a_we = 2'b01;
    a_addr[5:0] = 6'd5; a_wdata[31:0] = 32'hDEADBEEF;
    b_valid = 3'b111;
    #15;
    chk("rst_a_ready", 128'(a_ready), 128'(0));
    chk("rst_a_rv", 128'(a_rv), 128'(0));
    chk("rst_b_ready", 128'(b_ready), 128'(0));
    chk("rst_b_rv", 128'(b_rv), 128'(0));
    chk("rst_b_rdata", 128'(b_rdata), 128'(0));
    b_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_a_ready", 128'(a_ready), 128'(2'b01));

    // single port write then read, latency 1
    @(negedge clk); a_we = 2'b00; #1;
    chk("wr_ack_rv", 128'(a_rv), 128'(2'b01));
    chk("wr_ack_rdata", 128'(a_rdata), 128'(0));
    chk("rd_ready", 128'(a_ready), 128'(2'b01));

    @(negedge clk);
    a_valid = 2'b11; a_addr = {6'd5, 6'd5}; #1;
    chk("rd_rv", 128'(a_rv), 128'(2'b01));
    chk("rd_rdata", 128'(a_rdata), 128'(64'hDEADBEEF));
    chk("rr_ready_p1", 128'(a_ready), 128'(2'b10));

    @(negedge clk); a_valid = 2'b01; #1;
    chk("p1_rv", 128'(a_rv), 128'(2'b10));
    chk("p1_rdata", 128'(a_rdata), 128'({32'hDEADBEEF, 32'h0}));
    chk("rr_ready_p0", 128'(a_ready), 128'(2'b01));

    @(negedge clk); a_valid = 2'b00; #1;
    chk("p0_rv", 128'(a_rv), 128'(2'b01));
    chk("p0_rdata", 128'(a_rdata), 128'(64'hDEADBEEF));
    chk("idle_ready", 128'(a_ready), 128'(0));

    @(negedge clk); #1;
    chk("idle_rv", 128'(a_rv), 128'(0));
    chk("idle_rdata", 128'(a_rdata), 128'(0));

    // latency 3: preload 0..3, then four back-to-back reads
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      b_valid = '0; b_we = '0;
      if (i < 4) b_req(0, 1'b1, 6'(i), 32'(16 + i));
      else if (i < 8) b_req(0, 1'b0, 6'(i - 4), 32'h0);
      #1;
      ev = (i >= 3 && i <= 10) ? 3'b001 : 3'b000;
      ed = (i >= 7 && i <= 10) ? 96'(16 + i - 7) : 96'(0);
      chk("lat_ready", 128'(b_ready), 128'((i < 8) ? 3'b001 : 3'b000));
      chk("lat_rv", 128'(b_rv), 128'(ev));
      chk("lat_rdata", 128'(b_rdata), 128'(ed));
    end

    // two reads in flight from port1, pointer left at 2, then reset
    @(negedge clk);
    b_valid = '0; b_req(1, 1'b0, 6'd1, 32'h0); #1;
    chk("fl_ready0", 128'(b_ready), 128'(3'b010));
    @(negedge clk); #1;
    chk("fl_ready1", 128'(b_ready), 128'(3'b010));
    @(negedge clk);
    b_valid = '0;
    for (int p = 0; p < 3; p++) b_req(p, 1'b0, 6'(p), 32'h0);
    reset = 1'b1; #1;
    chk("mid_rst_ready", 128'(b_ready), 128'(0));
    chk("mid_rst_rv", 128'(b_rv), 128'(0));
    @(negedge clk); #1;
    chk("mid_rst_rv2", 128'(b_rv), 128'(0));
    chk("mid_rst_ready2", 128'(b_ready), 128'(0));

    // all three ports reading continuously: grants 0,1,2,0,1,2
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) reset = 1'b0;
      b_valid = (k < 6) ? 3'b111 : 3'b000;
      #1;
      ev = '0; ed = '0;
      if (k >= 3 && k <= 8) begin
        ev = 3'b001 << ((k - 3) % 3);
        ed = 96'(16 + (k - 3) % 3) << (32 * ((k - 3) % 3));
      end
      chk("rr3_ready", 128'(b_ready),
          128'((k < 6) ? (3'b001 << (k % 3)) : 3'b000));
      chk("rr3_rv", 128'(b_rv), 128'(ev));
      chk("rr3_rdata", 128'(b_rdata), 128'(ed));
    end

    // address 50 on a 48-deep memory
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      b_valid = '0; b_we = '0;
      case (i)
        0: b_req(0, 1'b1, 6'd18, 32'hA5A5A5A5);
        1: b_req(0, 1'b1, 6'd50, 32'h1);
        2: b_req(0, 1'b0, 6'd50, 32'h0);
        3: b_req(0, 1'b0, 6'd18, 32'h0);
        default: b_valid = '0;
      endcase
      #1;
      ev = (i >= 3 && i <= 6) ? 3'b001 : 3'b000;
      ed = '0;
      er = '0;
`ifdef SOC_DMEM_RANGE_CHK_EN
      if (i == 6) ed = 96'h0A5A5A5A5;
      if (i == 4 || i == 5) er = 3'b001;
      chk("oor_err", 128'(b_err), 128'(er));
`else
      if (i == 5 || i == 6) ed = 96'h1;
      er = '0;
`endif
      chk("oor_ready", 128'(b_ready), 128'((i < 4) ? 3'b001 : 3'b000));
      chk("oor_rv", 128'(b_rv), 128'(ev));
      chk("oor_rdata", 128'(b_rdata), 128'(ed));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
